// File: rtl/cbus_arb_pkg.sv
// Arbiter state encoding and grant-index width helper.
package cbus_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cbus_pkg.sv
// Shared CBus request/response types used by the bus converters and arbiter.
package cbus_pkg;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [7:0]  len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

endpackage

// File: rtl/cbus_arb_pick.sv
// Combinational winner picker: fixed priority, or rotating search from ptr
// when CBUS_ARB_RR_EN is defined.
module cbus_arb_pick
    import cbus_arb_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic               any_valid,
    output logic [IDX_W-1:0]   winner
);

    logic             found;
    logic [IDX_W-1:0] idx;

`ifndef CBUS_ARB_RR_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;
`endif

    assign any_valid = |valid;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef CBUS_ARB_RR_EN
            idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
`else
            idx = IDX_W'(k);
`endif
            if (!found && valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/cbus_arbiter.sv
// Per-transaction CBus arbiter: grant held from first beat to last ack.
// Define CBUS_ARB_RR_EN for round-robin instead of fixed priority.
module cbus_arbiter
    import cbus_pkg::*;
    import cbus_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  cbus_req_t  [NUM_REQ-1:0]     ireqs,
    output cbus_resp_t [NUM_REQ-1:0]     iresps,
    output cbus_req_t                    oreq,
    input  cbus_resp_t                   oresp
);

    localparam int IDX_W = idx_w(NUM_REQ);

    arb_state_t         state;
    logic [IDX_W-1:0]   sel;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   winner;
    logic [NUM_REQ-1:0] valid_vec;
    logic               any_valid;
    logic               done;

    always_comb begin
        valid_vec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            valid_vec[i] = ireqs[i].valid;
        end
    end

    cbus_arb_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .valid     (valid_vec),
        .ptr       (ptr),
        .any_valid (any_valid),
        .winner    (winner)
    );

    assign done = (state == BUSY) && oresp.ready && oresp.last;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            sel   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_valid) begin
                        sel   <= winner;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CBUS_ARB_RR_EN
    // Next search starts just past the requester that was served.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr <= '0;
        end else if (done) begin
            ptr <= (sel == IDX_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
        end
    end
`else
    assign ptr = '0;
`endif

    always_comb begin
        oreq   = '0;
        iresps = '0;
        if (state == BUSY) begin
            oreq        = ireqs[sel];
            iresps[sel] = oresp;
        end
    end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Self-checking bench for cbus_arbiter (NUM_REQ=2).
module tb_cbus_arbiter;
    import cbus_pkg::*;

    logic                  clk = 1'b0;
    logic                  resetn;
    cbus_req_t  [1:0]      ireqs;
    cbus_resp_t [1:0]      iresps;
    cbus_req_t             oreq;
    cbus_resp_t            oresp;

    always #5 clk = ~clk;

    cbus_arbiter #(
        .NUM_REQ (2)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .ireqs  (ireqs),
        .iresps (iresps),
        .oreq   (oreq),
        .oresp  (oresp)
    );

    typedef struct {
        int          who;
        logic [31:0] data;
        logic        last;
    } exp_t;

    typedef struct {
        logic [1:0] v;
        logic       grant;
        int         win;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[5];
    int   checks = 0;
    int   passed = 0;

    localparam logic [31:0] A0 = 32'h0000_0400;
    localparam logic [31:0] A1 = 32'h0000_0800;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        ireqs  = '0;
        oresp  = '0;
        tick();
        resetn = 1'b1;
    endtask

    function automatic cbus_req_t mkreq(input logic w, input logic [31:0] a,
                                        input logic [7:0] l,
                                        input logic [31:0] d);
        cbus_req_t r;
        r          = '0;
        r.valid    = 1'b1;
        r.is_write = w;
        r.size     = 3'd2;
        r.addr     = a;
        r.strobe   = w ? 4'hF : 4'h0;
        r.data     = d;
        r.len      = l;
        return r;
    endfunction

    // Drive one memory beat and record what the requester must see.
    task automatic beat(input int who, input logic [31:0] d,
                        input logic last);
        oresp.ready = 1'b1;
        oresp.last  = last;
        oresp.data  = d;
        sbq.push_back('{who, d, last});
        tick();
        oresp = '0;
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (iresps[i].ready) begin
                if (sbq.size() == 0) begin
                    check("sb unexpected ready", 128'(i), 128'(99));
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("sb requester", 128'(i), 128'(e.who));
                    check("sb data", 128'(iresps[i].data), 128'(e.data));
                    check("sb last", 128'(iresps[i].last), 128'(e.last));
                    check("sb other idle", 128'(iresps[1-i]), 128'(0));
                end
            end
        end
    end

    initial begin
        cbus_req_t wr;
        int        exp_w;

        vecs[0] = '{2'b01, 1'b1, 0};
        vecs[1] = '{2'b10, 1'b1, 1};
        vecs[2] = '{2'b11, 1'b1, 0};
`ifdef CBUS_ARB_RR_EN
        vecs[3] = '{2'b11, 1'b1, 1};
`else
        vecs[3] = '{2'b11, 1'b1, 0};
`endif
        vecs[4] = '{2'b00, 1'b0, 0};

        resetn = 1'b0;
        ireqs  = '0;
        oresp  = '0;
        #2;
        check("rst oreq", 128'(oreq), 128'(0));
        check("rst iresps", 128'(iresps), 128'(0));
        tick();
        tick();
        resetn = 1'b1;

        // Table of request patterns, one transaction each.
        for (int i = 0; i < 5; i++) begin
            ireqs[0] = vecs[i].v[0] ? mkreq(1'b0, A0, 8'd0, 32'h0) : '0;
            ireqs[1] = vecs[i].v[1] ? mkreq(1'b0, A1, 8'd0, 32'h0) : '0;
            #1;
            check("vec idle gap", 128'(oreq.valid), 128'(0));
            tick();
            check("vec grant", 128'(oreq.valid), 128'(vecs[i].grant));
            if (vecs[i].grant) begin
                check("vec winner addr", 128'(oreq.addr),
                      128'(vecs[i].win == 0 ? A0 : A1));
                beat(vecs[i].win, 32'h100 + 32'(i), 1'b1);
            end
            ireqs = '0;
        end

        // Single requester 1, four-beat read.
        do_reset();
        ireqs[1] = mkreq(1'b0, 32'h1000, 8'd3, 32'h0);
        #1;
        check("s2 no grant yet", 128'(oreq.valid), 128'(0));
        tick();
        check("s2 grant latency", 128'(oreq.valid), 128'(1));
        check("s2 addr", 128'(oreq.addr), 128'(32'h1000));
        for (int b = 0; b < 4; b++) begin
            beat(1, 32'hA000 + 32'(b), b == 3);
        end
        ireqs[1] = '0;
        #1;
        check("s2 idle after", 128'(oreq.valid), 128'(0));

        // Simultaneous requests, req0 two beats.
        do_reset();
        ireqs[0] = mkreq(1'b0, A0, 8'd1, 32'h0);
        ireqs[1] = mkreq(1'b0, A1, 8'd0, 32'h0);
        tick();
        check("s3 first addr", 128'(oreq.addr), 128'(A0));
        beat(0, 32'hB000, 1'b0);
        beat(0, 32'hB001, 1'b1);
        ireqs[0] = '0;
        #1;
        check("s3 gap", 128'(oreq.valid), 128'(0));
        tick();
        check("s3 second valid", 128'(oreq.valid), 128'(1));
        check("s3 second addr", 128'(oreq.addr), 128'(A1));
        beat(1, 32'hB002, 1'b1);
        ireqs = '0;

        // Continuous contention for four transactions.
        do_reset();
        ireqs[0] = mkreq(1'b0, A0, 8'd0, 32'h0);
        ireqs[1] = mkreq(1'b0, A1, 8'd0, 32'h0);
        for (int t = 0; t < 4; t++) begin
`ifdef CBUS_ARB_RR_EN
            exp_w = t % 2;
`else
            exp_w = 0;
`endif
            tick();
            check("s4 order", 128'(oreq.addr), 128'(exp_w == 0 ? A0 : A1));
            beat(exp_w, 32'hC000 + 32'(t), 1'b1);
            #1;
            check("s4 gap", 128'(oreq.valid), 128'(0));
        end
        ireqs = '0;

        // Single-beat write pass-through.
        do_reset();
        wr = mkreq(1'b1, 32'h2000, 8'd0, 32'hDEADBEEF);
        ireqs[0] = wr;
        tick();
        check("s6 oreq fields", 128'(oreq), 128'(wr));
        beat(0, 32'h0, 1'b1);
        #1;
        check("s6 valid drops", 128'(oreq.valid), 128'(0));
        ireqs = '0;

        // Reset mid-transaction.
        do_reset();
        ireqs[0] = mkreq(1'b0, 32'h3000, 8'd3, 32'h0);
        tick();
        beat(0, 32'hD000, 1'b0);
        beat(0, 32'hD001, 1'b0);
        oresp.ready = 1'b1;
        oresp.last  = 1'b1;
        oresp.data  = 32'hD002;
        #1;
        resetn = 1'b0;
        #1;
        check("s1 oreq in reset", 128'(oreq.valid), 128'(0));
        check("s1 iresps in reset", 128'(iresps), 128'(0));
        ireqs = '0;
        oresp = '0;
        tick();
        resetn = 1'b1;
        #1;
        check("s1 idle after", 128'(oreq.valid), 128'(0));
        tick();
        check("s1 no regrant", 128'(oreq.valid), 128'(0));

        tick();
        check("sb drained", 128'(sbq.size()), 128'(0));
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/cbus_arbiter.md
Name: cbus_arbiter

Overview:
- Shares the single cache-bus (CBus) master port between NUM_REQ requesters. The baseline pairing is the I-side converter (index 0) and the D-side converter (index 1).
- Sits in the top-level between the bus converters and the external oreq/oresp port, and replaces the stateless multiplexer there.
- Grants one requester per complete transaction and holds that grant until the final beat is acknowledged.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..8.
- IDX_W, $clog2(NUM_REQ), width of the grant index; derived, not overridable.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- ireqs  in  NUM_REQ x cbus_req_t  requester requests.
- iresps  out  NUM_REQ x cbus_resp_t  per-requester responses.
- oreq  out  cbus_req_t  request to the memory side.
- oresp  in  cbus_resp_t  response from the memory side.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low; ports are named clk and resetn.
- CBus request fields: valid, is_write, size, addr, strobe, data, len.
- CBus response fields: ready, last, data.
- State machine: states IDLE and BUSY; registers sel (IDX_W bits) and, under the option, ptr.
- Reset (resetn=0, asynchronous):
  - state=IDLE, sel=0, ptr=0.
  - oreq='0, so oreq.valid=0 in the same cycle reset asserts.
  - All iresps='0.
  - A transaction in flight is abandoned, with no completion signalled to any requester.
- IDLE behaviour:
  - oreq='0 and all iresps='0.
  - If any ireqs[i].valid=1, the winner from the picker is latched into sel; next state is BUSY.
  - If no request is valid, state stays IDLE.
- Grant latency: 1 cycle from the first valid request to oreq.valid=1.
- BUSY behaviour:
  - oreq=ireqs[sel], forwarded combinationally.
  - iresps[sel]=oresp.
  - iresps[j]='0 for every j!=sel.
  - The oresp.ready/last of the granted requester pass through with zero added latency.
- BUSY to IDLE: on the cycle where oresp.ready=1 and oresp.last=1.
- Back-to-back transactions:
  - After completion there is at least one IDLE cycle, with oreq.valid=0.
  - One requester therefore occupies the bus for at most one transaction per grant.
- Requester obligation: valid and all request fields stay stable from the grant until the last beat.
- Requester dropping valid mid-transaction: the grant is still held and the field values are forwarded unchanged. The arbiter never aborts a transaction; no recovery is defined.
- Non-selected requesters: may assert valid at any time; they wait and see ready=0.
- Single-beat transactions (len=0): the first ready also carries last=1, so one BUSY cycle suffices.
- Simultaneous events: completion and new requests in the same cycle are not arbitrated until the following IDLE cycle.
- Default picker (fixed priority): the lowest valid index wins. With NUM_REQ=2, requester 0 beats requester 1.

Optional Feature:
- Macro: CBUS_ARB_RR_EN.
- When defined, arbitration is round-robin:
  - Search starts at ptr and wraps modulo NUM_REQ.
  - On each completion, ptr <= sel+1; for NUM_REQ not a power of two, sel=NUM_REQ-1 wraps to 0.
  - ptr resets to 0.
  - A continuously requesting port waits at most NUM_REQ-1 transactions.
- When undefined:
  - Fixed priority as above.
  - No ptr register is instantiated.
  - Starvation of high indices is permitted.

Decomposition:
- cbus_req_t and cbus_resp_t remain in the existing shared common header; nothing is duplicated.
- The shared package cbus_arb_pkg holds:
  - the arb_state_t enum {IDLE, BUSY};
  - the function or localparam for IDX_W.
- Sub-module cbus_arb_pick (combinational):
  - inputs: valid vector and ptr;
  - outputs: any_valid and winner index;
  - implements both fixed-priority and rotate-search.
- cbus_arbiter holds the state machine, the sel/ptr registers and the muxing.

Test Plan:
1. Reset during BUSY: requester 0 grants a len=3 read, then resetn drops after 2 beats. Required: oreq.valid=0 and iresps all 0 immediately; state=IDLE after resetn rises; no last delivered to any requester.
2. Single requester: requester 1 issues a read, addr=0x1000, len=3; memory returns 4 beats with ready on each. Required: oreq.valid rises 1 cycle after ireqs[1].valid; iresps[1] sees 4 ready beats, last on the 4th; iresps[0] stays 0; IDLE follows.
3. Simultaneous requests, default build: both requesters valid in cycle 0. Required: requester 0 is served first; requester 1 is granted in the IDLE cycle after requester 0's last and appears on oreq 1 cycle later.
4. Simultaneous requests with CBUS_ARB_RR_EN: both requesters hold valid continuously for 4 transactions. Required: grant order 0,1,0,1.
5. Continuous contention, default build: same stimulus as scenario 4. Required: grant order 0,0,0,0.
6. Write pass-through: requester 0 issues a write, strobe=0xF, data=0xDEADBEEF, len=0. Required: oreq fields bit-identical to ireqs[0]; completion on the first ready with last=1; oreq.valid=0 on the next cycle.
